pc_redirect_unit: RTL and testbench

//   Parametrised program-counter unit for the pipelined core's fetch stage.

---
 rtl/pc_redirect_unit.sv | 140 ++++++++++++++
 tb/tb_pc_redirect_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit
//   Fetch-stage program counter with redirect capture and flush generation.
//
//   Next-PC priority: trap > resolved redirect > pending redirect > sequential.
//   A redirect or trap that arrives while fetch cannot advance is held in
//   pend_pc and applied on the first cycle fetch can advance. A newer event
//   arriving while one is pending replaces it.
//   Each time a non-sequential target is loaded into the PC ("take"), a
//   one-cycle pulse walks down flush[0..FLUSH_STAGES-1], one stage per cycle.
//   The pulse train ignores stall.
//
// Parameters
//   W            PC width
//   RESET_VEC    PC value held in reset
//   INC          sequential increment, added modulo 2^W
//   FLUSH_STAGES number of flush outputs (>= 1)
//
// Ports
//   clk, rst       clock (rising edge), async active-high reset
//   pc_write       PC update enable from hazard unit
//   stall          fetch stall, PC holds while high
//   redir_valid/pc resolved branch/jump redirect, one-cycle pulse
//   trap_valid/pc  trap redirect, one-cycle pulse, beats redir_valid
//   pc             current fetch PC (registered)
//   pc_valid       pc holds a valid fetch address
//   redir_pending  a captured redirect waits to be applied
//   flush          flush[i] kills the wrong-path entry in front-end stage i
// ---------------------------------------------------------------------------
module pc_redirect_unit #(
  parameter int unsigned    W            = 32,
  parameter logic [W-1:0]   RESET_VEC    = '0,
  parameter int unsigned    INC          = 4,
  parameter int unsigned    FLUSH_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pc_write,
  input  logic                    stall,
  input  logic                    redir_valid,
  input  logic [W-1:0]            redir_pc,
  input  logic                    trap_valid,
  input  logic [W-1:0]            trap_pc,
  output logic [W-1:0]            pc,
  output logic                    pc_valid,
  output logic                    redir_pending,
  output logic [FLUSH_STAGES-1:0] flush
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [W-1:0]          pc_q, pc_d;
  logic [W-1:0]          pend_pc_q, pend_pc_d;
  logic                  pc_valid_q;
  // vld_pipe_q[0] marks "a take happened at the last edge"; the PC already
  // shows the new target then, so the flush train starts one stage later.
  logic [FLUSH_STAGES:0] vld_pipe_q, vld_pipe_d;

  logic                  adv;
  logic                  evt;
  logic [W-1:0]          evt_pc;
  logic                  take;

  assign adv    = pc_write & ~stall;
  assign evt    = trap_valid | redir_valid;
  // A trap beats a simultaneous redirect; the redirect is simply dropped.
  assign evt_pc = trap_valid ? trap_pc : redir_pc;

  // -------------------------------------------------------------------------
  // Next-state / next-PC selection
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    take      = 1'b0;
    case (state_q)
      RUN: begin
        if (evt && adv) begin
          pc_d = evt_pc;
          take = 1'b1;
        end else if (evt) begin
          // Fetch is blocked: park the target until fetch can move.
          pend_pc_d = evt_pc;
          state_d   = PEND;
        end else if (adv) begin
          pc_d = pc_q + W'(INC);
        end
      end
      PEND: begin
        if (evt) begin
          // Newest event replaces the parked one; applied now if possible.
          pend_pc_d = evt_pc;
          if (adv) begin
            pc_d    = evt_pc;
            take    = 1'b1;
            state_d = RUN;
          end
        end else if (adv) begin
          pc_d    = pend_pc_q;
          take    = 1'b1;
          state_d = RUN;
        end
        // No sequential increment while a target is parked.
      end
      default: state_d = RUN;
    endcase
  end

  assign vld_pipe_d = {vld_pipe_q[FLUSH_STAGES-1:0], take};

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_VEC;
      pend_pc_q  <= '0;
      pc_valid_q <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      pc_valid_q <= 1'b1;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign pc            = pc_q;
  assign pc_valid      = pc_valid_q;
  assign redir_pending = (state_q == PEND);
  assign flush         = vld_pipe_q[FLUSH_STAGES:1];

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;
  localparam int W  = 32;
  localparam int FS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pc_write = 1'b0, stall = 1'b0;
  logic          redir_valid = 1'b0, trap_valid = 1'b0;
  logic [W-1:0]  redir_pc = '0, trap_pc = '0;
  logic [W-1:0]  pc;
  logic          pc_valid, redir_pending;
  logic [FS-1:0] flush;

  pc_redirect_unit #(.W(W), .RESET_VEC('0), .INC(4), .FLUSH_STAGES(FS)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .stall(stall),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .pc(pc), .pc_valid(pc_valid), .redir_pending(redir_pending), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  pc;
    logic          pv;
    logic          pend;
    logic [FS-1:0] flush;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural view of fetch
  logic [W-1:0] m_pc   = '0;
  logic         m_pv   = 1'b0;
  logic         m_pend = 1'b0;
  logic [W-1:0] m_tgt  = '0;
  bit           hist[$];   // per edge since reset: was a target loaded?

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected record per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_valid", W'(pc_valid), W'(e.pv));
        chk("redir_pending", W'(redir_pending), W'(e.pend));
        chk("flush", W'(flush), W'(e.flush));
      end
    end
  end

  task automatic step(input bit r, input bit pw, input bit st,
                      input bit rv, input logic [W-1:0] rp,
                      input bit tv, input logic [W-1:0] tp);
    exp_t e;
    bit   was_rst, adv, ev, tk;
    logic [W-1:0] tgt;
    int   k;
    @(negedge clk);
    was_rst     = rst;
    rst         = r;
    pc_write    = pw;
    stall       = st;
    redir_valid = rv;
    redir_pc    = rp;
    trap_valid  = tv;
    trap_pc     = tp;
    if (r) begin
      if (!was_rst) begin
        // Reset is asynchronous: outputs must clear before the next edge.
        #1;
        chk("async_rst_pc", pc, '0);
        chk("async_rst_pv", W'(pc_valid), '0);
        chk("async_rst_pend", W'(redir_pending), '0);
        chk("async_rst_flush", W'(flush), '0);
      end
      m_pc = '0; m_pv = 1'b0; m_pend = 1'b0; m_tgt = '0;
      hist.delete();
      e.flush = '0;
    end else begin
      adv = pw && !st;
      ev  = rv || tv;
      tgt = tv ? tp : rp;
      tk  = 1'b0;
      if (adv) begin
        if (ev)          begin m_pc = tgt;   tk = 1'b1; m_pend = 1'b0; end
        else if (m_pend) begin m_pc = m_tgt; tk = 1'b1; m_pend = 1'b0; end
        else             m_pc = m_pc + 4;
      end else if (ev) begin
        m_pend = 1'b1;
        m_tgt  = tgt;
      end
      m_pv = 1'b1;
      hist.push_back(tk);
      k = hist.size() - 1;
      // Load at edge j -> flush[i] visible just after edge j+1+i.
      for (int i = 0; i < FS; i++)
        e.flush[i] = (k - 1 - i >= 0) ? hist[k-1-i] : 1'b0;
    end
    e.pc = m_pc; e.pv = m_pv; e.pend = m_pend;
    q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, '0, 0, '0);
  endtask

  initial begin
    // T1 reset then sequential fetch
    repeat (3) step(1, 1, 0, 0, '0, 0, '0);
    run(4);
    step(0, 0, 0, 0, '0, 0, '0);                     // pc_write low: hold
    // T2 redirect with advance, flush train
    step(0, 1, 0, 1, 32'h20, 0, '0);
    step(0, 1, 0, 1, 32'h100, 0, '0);
    run(3);
    // T3 redirect while stalled, replay on release
    step(0, 1, 1, 1, 32'h200, 0, '0);
    step(0, 1, 1, 0, '0, 0, '0);
    step(0, 1, 1, 0, '0, 0, '0);
    step(0, 1, 0, 0, '0, 0, '0);
    run(3);
    // T4 trap beats redirect; trap overrides a pending redirect
    step(0, 1, 0, 1, 32'h300, 1, 32'h80);
    run(3);
    step(0, 1, 1, 1, 32'h300, 0, '0);
    step(0, 1, 1, 0, '0, 1, 32'h90);
    step(0, 1, 0, 0, '0, 0, '0);
    step(0, 0, 0, 1, 32'h300, 0, '0);
    step(0, 1, 0, 0, '0, 1, 32'hA0);                 // trap with adv in PEND
    run(3);
    // T5 wrap-around, no flush on sequential wrap
    step(0, 1, 0, 1, 32'hFFFF_FFF0, 0, '0);
    run(5);
    // T6 async reset while a redirect is pending; nothing replayed
    step(0, 1, 1, 1, 32'h400, 0, '0);
    step(1, 1, 0, 0, '0, 0, '0);
    step(1, 1, 0, 0, '0, 0, '0);
    run(3);
    // Random phase
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 11) == 0, $urandom & 32'hFFFF_FFFC);
    run(4);
    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
